// File: rtl/ee354_gcd_pkg.sv
// Shared constants for the GCD engine: one-hot state codes and algorithm mode selectors.
package ee354_gcd_pkg;

    localparam logic [3:0] QI    = 4'b1000;
    localparam logic [3:0] QSUB  = 4'b0100;
    localparam logic [3:0] QMULT = 4'b0010;
    localparam logic [3:0] QDONE = 4'b0001;

    localparam logic MODE_EUCLID = 1'b0;
    localparam logic MODE_STEIN  = 1'b1;

    typedef enum logic [3:0] {
        ST_I    = QI,
        ST_SUB  = QSUB,
        ST_MULT = QMULT,
        ST_DONE = QDONE
    } state_t;

endpackage

// File: rtl/ee354_gcd_param.sv
// Parameterised GCD engine: subtractive Euclid or binary Stein, with the common
// power of two re-applied in q_Mult and a saturating cycle counter.
module ee354_gcd_param
    import ee354_gcd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             CEN,
    input  logic             Start,
    input  logic             Ack,
    input  logic             Mode,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] AB_GCD,
    output logic [CNT_W-1:0] i_count,
    output logic [15:0]      Cycles,
    output logic             q_I,
    output logic             q_Sub,
    output logic             q_Mult,
    output logic             q_Done
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state, state_n;
    logic [WIDTH-1:0] a_reg, a_n, b_reg, b_n, gcd_reg, gcd_n;
    logic [CNT_W-1:0] cnt_reg, cnt_n;
    logic [15:0]      cyc_reg, cyc_n, cyc_inc;
    logic             mode_reg, mode_n;
    logic             stein;

    assign cyc_inc = (cyc_reg == 16'hFFFF) ? cyc_reg : cyc_reg + 16'd1;
    assign stein   = (mode_reg == MODE_STEIN);

    always_comb begin
        state_n = state;
        a_n     = a_reg;
        b_n     = b_reg;
        gcd_n   = gcd_reg;
        cnt_n   = cnt_reg;
        cyc_n   = cyc_reg;
        mode_n  = mode_reg;
        case (state)
            ST_I: begin
                if (Start) begin
                    a_n     = Ain;
                    b_n     = Bin;
                    gcd_n   = '0;
                    cnt_n   = '0;
                    cyc_n   = '0;
                    mode_n  = Mode;
                    state_n = ST_SUB;
                end
            end
            ST_SUB: begin
                cyc_n = cyc_inc;
                if (a_reg == '0) begin
                    gcd_n   = b_reg;
                    state_n = ST_MULT;
                end else if (b_reg == '0 || a_reg == b_reg) begin
                    gcd_n   = a_reg;
                    state_n = ST_MULT;
                end else if (stein && !a_reg[0] && !b_reg[0]) begin
                    a_n   = a_reg >> 1;
                    b_n   = b_reg >> 1;
                    cnt_n = cnt_reg + CNT_ONE;
                end else if (stein && !a_reg[0]) begin
                    a_n = a_reg >> 1;
                end else if (stein && !b_reg[0]) begin
                    b_n = b_reg >> 1;
                end else if (a_reg > b_reg) begin
                    a_n = a_reg - b_reg;
                end else begin
                    b_n = b_reg - a_reg;
                end
            end
            // Each extracted common factor of two is restored one shift per cycle.
            ST_MULT: begin
                cyc_n = cyc_inc;
                if (cnt_reg == '0) begin
                    state_n = ST_DONE;
                end else begin
                    gcd_n = gcd_reg << 1;
                    cnt_n = cnt_reg - CNT_ONE;
                end
            end
            ST_DONE: begin
                if (Ack) state_n = ST_I;
            end
            default: state_n = ST_I;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= ST_I;
            a_reg    <= '0;
            b_reg    <= '0;
            gcd_reg  <= '0;
            cnt_reg  <= '0;
            cyc_reg  <= '0;
            mode_reg <= MODE_EUCLID;
        end else if (CEN) begin
            state    <= state_n;
            a_reg    <= a_n;
            b_reg    <= b_n;
            gcd_reg  <= gcd_n;
            cnt_reg  <= cnt_n;
            cyc_reg  <= cyc_n;
            mode_reg <= mode_n;
        end
    end

    assign A       = a_reg;
    assign B       = b_reg;
    assign AB_GCD  = gcd_reg;
    assign i_count = cnt_reg;
    assign Cycles  = cyc_reg;
    assign q_I     = (state == ST_I);
    assign q_Sub   = (state == ST_SUB);
    assign q_Mult  = (state == ST_MULT);
    assign q_Done  = (state == ST_DONE);

endmodule

// File: tb/tb_ee354_gcd_param.sv
// Randomised self-checking bench for ee354_gcd_param at WIDTH=8 and WIDTH=16,
// compared against an arithmetic GCD reference and a step-count model.
module tb_ee354_gcd_param;
    import ee354_gcd_pkg::*;

    logic        clk = 1'b0, reset = 1'b1, cen = 1'b1, ack = 1'b0, mode = 1'b0;
    logic        start8 = 1'b0, start16 = 1'b0;
    logic [7:0]  ain8 = '0, bin8 = '0;
    logic [15:0] ain16 = '0, bin16 = '0;

    logic [7:0]  a8, b8, g8;
    logic [3:0]  cnt8;
    logic [15:0] cyc8;
    logic        qi8, qs8, qm8, qd8;
    logic [15:0] a16, b16, g16;
    logic [4:0]  cnt16;
    logic [15:0] cyc16;
    logic        qi16, qs16, qm16, qd16;

    int checkCount = 0;
    int passCount  = 0;
    int unsigned lastGcd, lastCyc;

    ee354_gcd_param #(.WIDTH(8)) dut8 (
        .Clk(clk), .Reset(reset), .CEN(cen), .Start(start8), .Ack(ack), .Mode(mode),
        .Ain(ain8), .Bin(bin8), .A(a8), .B(b8), .AB_GCD(g8), .i_count(cnt8),
        .Cycles(cyc8), .q_I(qi8), .q_Sub(qs8), .q_Mult(qm8), .q_Done(qd8)
    );

    ee354_gcd_param #(.WIDTH(16)) dut16 (
        .Clk(clk), .Reset(reset), .CEN(cen), .Start(start16), .Ack(ack), .Mode(mode),
        .Ain(ain16), .Bin(bin16), .A(a16), .B(b16), .AB_GCD(g16), .i_count(cnt16),
        .Cycles(cyc16), .q_I(qi16), .q_Sub(qs16), .q_Mult(qm16), .q_Done(qd16)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input longint unsigned actual,
                               input longint unsigned expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    endtask

    function automatic int unsigned modGcd(input int unsigned x, input int unsigned y);
        int unsigned t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Walks the algorithm's arithmetic rules to predict step count, factor count and exit operands.
    task automatic refModel(input int unsigned a, input int unsigned b, input bit m,
                            output int unsigned k, output int unsigned fa,
                            output int unsigned fb, output int unsigned cyc);
        int unsigned steps = 0;
        k = 0;
        while (!(a == 0 || b == 0 || a == b)) begin
            if (m && a % 2 == 0 && b % 2 == 0) begin a = a / 2; b = b / 2; k++; end
            else if (m && a % 2 == 0) a = a / 2;
            else if (m && b % 2 == 0) b = b / 2;
            else if (a > b) a = a - b;
            else b = b - a;
            steps++;
        end
        fa  = a;
        fb  = b;
        cyc = steps + 2 + k;
        if (cyc > 65535) cyc = 65535;
    endtask

    task automatic sampleOut(input bit wide, output int unsigned oa, output int unsigned ob,
                             output int unsigned og, output int unsigned ocnt,
                             output int unsigned ocyc, output logic [3:0] fl);
        if (wide) begin
            oa = a16; ob = b16; og = g16; ocnt = cnt16; ocyc = cyc16;
            fl = {qi16, qs16, qm16, qd16};
        end else begin
            oa = a8; ob = b8; og = g8; ocnt = cnt8; ocyc = cyc8;
            fl = {qi8, qs8, qm8, qd8};
        end
    endtask

    task automatic applyStimulus(input bit wide, input bit m, input int unsigned a,
                                 input int unsigned b, input int freezeAt);
        int unsigned k, fa, fb, expCyc, expGcd, maxCnt;
        int unsigned oa, ob, og, ocnt, ocyc;
        int unsigned sa, sb, scnt, scyc;
        logic [3:0]  fl, sfl;
        bit          badHot = 1'b0;
        int          n = 0;
        refModel(a, b, m, k, fa, fb, expCyc);
        expGcd = modGcd(a, b);
        @(negedge clk);
        mode = m;
        if (wide) begin ain16 = 16'(a); bin16 = 16'(b); start16 = 1'b1; end
        else      begin ain8  = 8'(a);  bin8  = 8'(b);  start8  = 1'b1; end
        @(negedge clk);
        start8 = 1'b0; start16 = 1'b0;
        mode = ~m;
        maxCnt = 0;
        while (1) begin
            sampleOut(wide, oa, ob, og, ocnt, ocyc, fl);
            if (!$onehot(fl)) badHot = 1'b1;
            if (ocnt > maxCnt) maxCnt = ocnt;
            if (fl == QDONE || n >= 5000) break;
            if (freezeAt > 0 && n == freezeAt) begin
                cen = 1'b0;
                sa = oa; sb = ob; scnt = ocnt; scyc = ocyc; sfl = fl;
                repeat (10) @(negedge clk);
                sampleOut(wide, oa, ob, og, ocnt, ocyc, fl);
                checkOutput("hold_A", oa, sa);
                checkOutput("hold_B", ob, sb);
                checkOutput("hold_cnt", ocnt, scnt);
                checkOutput("hold_cycles", ocyc, scyc);
                checkOutput("hold_state", fl, sfl);
                cen = 1'b1;
            end
            @(negedge clk);
            n++;
        end
        checkOutput("reach_done", (fl == QDONE), 1);
        checkOutput("gcd", og, expGcd);
        checkOutput("cycles", ocyc, expCyc);
        checkOutput("peak_count", maxCnt, k);
        checkOutput("final_count", ocnt, 0);
        checkOutput("exit_A", oa, fa);
        checkOutput("exit_B", ob, fb);
        checkOutput("onehot", badHot, 0);
        lastGcd = og;
        lastCyc = ocyc;
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        sampleOut(wide, oa, ob, og, ocnt, ocyc, fl);
        checkOutput("ack_to_idle", fl, QI);
        checkOutput("idle_gcd_held", og, expGcd);
        checkOutput("idle_cycles_held", ocyc, expCyc);
    endtask

    initial begin
        int unsigned oa, ob, og, ocnt, ocyc;
        logic [3:0]  fl;
        int          n;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int w = 0; w < 2; w++) begin
            sampleOut(w[0], oa, ob, og, ocnt, ocyc, fl);
            checkOutput("reset_state", fl, QI);
            checkOutput("reset_outputs", oa + ob + og + ocnt + ocyc, 0);
        end

        applyStimulus(0, MODE_EUCLID, 36, 24, 0);
        checkOutput("euclid_36_24_gcd", lastGcd, 12);
        checkOutput("euclid_36_24_cycles", lastCyc, 4);
        applyStimulus(0, MODE_STEIN, 36, 24, 0);
        checkOutput("stein_36_24_gcd", lastGcd, 12);
        checkOutput("stein_36_24_cycles", lastCyc, 9);
        applyStimulus(0, MODE_STEIN, 0, 45, 0);
        checkOutput("stein_0_45_cycles", lastCyc, 2);
        applyStimulus(0, MODE_EUCLID, 0, 0, 0);
        applyStimulus(0, MODE_STEIN, 0, 0, 0);
        applyStimulus(1, MODE_EUCLID, 65535, 255, 0);
        checkOutput("wide_euclid_cycles", lastCyc, 258);
        applyStimulus(1, MODE_STEIN, 65535, 255, 0);
        checkOutput("wide_stein_gcd", lastGcd, 255);
        applyStimulus(0, MODE_STEIN, 36, 24, 3);
        checkOutput("cen_hold_cycles", lastCyc, 9);

        // Abort a run from q_Mult and confirm nothing survives the reset.
        @(negedge clk);
        mode = MODE_STEIN; ain8 = 8'd36; bin8 = 8'd24; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n = 0;
        while (!qm8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reach_mult", qm8, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sampleOut(0, oa, ob, og, ocnt, ocyc, fl);
        checkOutput("abort_state", fl, QI);
        checkOutput("abort_outputs", oa + ob + og + ocnt + ocyc, 0);
        applyStimulus(0, MODE_EUCLID, 21, 14, 0);
        checkOutput("after_abort_gcd", lastGcd, 7);

        repeat (24) applyStimulus(0, 1'($urandom_range(0, 1)), $urandom_range(0, 255),
                                  $urandom_range(0, 255), 0);
        repeat (6) applyStimulus(1, MODE_STEIN, $urandom_range(0, 65535),
                                 $urandom_range(0, 65535), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
